uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling, start-glitch rejection,

---
 rtl/uart_rx_fifo_pkg.sv | 15 +
 rtl/uart_rx_fifo_if.sv | 23 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 55 +++++
 rtl/uart_rx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive front end.
// Baud divisor for 100 MHz / 9600 and the receiver state encoding.
package uart_pkg;

  localparam int BAUD_DIV_9600 = 10416;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream from the UART receiver FIFO to its consumer.
// master = receiver side, slave = consumer side.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop frees a slot for a
// same-cycle push when full. dout reads 0 while empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  drop,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic do_push, do_pop;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop sync, mid-bit sampling, framing check, output FIFO.
// Optional parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DIVISOR    = BAUD_DIV_9600,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  data_in,
  uart_rx_fifo_if.master rx_if,
  output logic  frame_err,
  output logic  overrun,
`ifdef UART_RX_PARITY_EN
  output logic  parity_err,
`endif
  output logic  busy
);

  localparam int CW   = $clog2(DIVISOR);
  localparam int IW   = $clog2(DATA_WIDTH);
  localparam int HALF = DIVISOR / 2 - 1;

  logic sync1_q, sync2_q, line;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic sidx_q, sidx_d;
  logic stop_bad_q, stop_bad_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;
  logic par_bad_q, par_bad_d;
`ifdef UART_RX_PARITY_EN
  logic parity_err_q, parity_err_d;
`endif
  logic push, bad, mid;
  logic fifo_full, fifo_empty, fifo_drop;

  assign line = sync2_q;
  assign mid  = cnt_q == CW'(DIVISOR - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    sidx_d      = sidx_q;
    stop_bad_d  = stop_bad_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    par_bad_d   = par_bad_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    push = 1'b0;
    bad  = stop_bad_q | ~line;
    unique case (state_q)
      S_IDLE: begin
        if (!line) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (line) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(HALF)) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          idx_d     = '0;
          par_bad_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (mid) begin
          cnt_d          = '0;
          shift_d[idx_q] = line;
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            sidx_d     = 1'b0;
            stop_bad_d = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          cnt_d     = '0;
          state_d   = S_STOP;
          par_bad_d = (^shift_q ^ line) != PARITY_ODD;
          if (par_bad_d) parity_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (mid) begin
          cnt_d = '0;
          if (sidx_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            if (bad) frame_err_d = 1'b1;
            else if (!par_bad_q) push = 1'b1;
          end else begin
            sidx_d     = 1'b1;
            stop_bad_d = bad;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fifo_drop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      sidx_q      <= 1'b0;
      stop_bad_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      par_bad_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= data_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      sidx_q      <= sidx_d;
      stop_bad_q  <= stop_bad_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      par_bad_q   <= par_bad_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (push),
    .din   (shift_q),
    .pop   (rx_if.rx_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .dout  (rx_if.rx_data)
  );

  assign rx_if.rx_valid = ~fifo_empty;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign busy           = state_q != S_IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err     = parity_err_q;
`endif

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (DIVISOR=16, 8 data bits, depth 4).
// Sent bytes are queued as expected; drained bytes are compared in order.
module tb_uart_rx_fifo;

  localparam int DIV = 16;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b1;
  logic frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_WIDTH(DW)) rif ();

  uart_rx_fifo #(
    .DIVISOR    (DIV),
    .DATA_WIDTH (DW),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .data_in    (din),
    .rx_if      (rif),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  // pop_at >= 0 raises rx_ready for one cycle at that stop-bit drive slot
  task automatic send(input logic [DW-1:0] b, input logic stop,
                      input int pop_at);
    for (int i = 0; i < DIV; i++) begin @(negedge clk); din = 1'b0; end
    for (int k = 0; k < DW; k++)
      for (int i = 0; i < DIV; i++) begin @(negedge clk); din = b[k]; end
`ifdef UART_RX_PARITY_EN
    for (int i = 0; i < DIV; i++) begin @(negedge clk); din = ^b; end
`endif
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk);
      din = stop;
      if (pop_at >= 0) rif.rx_ready = (i == pop_at);
    end
    @(negedge clk);
    din = 1'b1;
  endtask

  task automatic drain(input int n);
    logic [DW-1:0] exp;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      @(negedge clk);
      while (!rif.rx_valid && t < 500) begin @(negedge clk); t++; end
      checks++;
      if (!rif.rx_valid) begin
        $display("FAIL drain_timeout rx_valid=%b want 1", rif.rx_valid);
        errors++;
      end else if (exp_q.size() == 0) begin
        $display("FAIL drain_extra got %h want no byte", rif.rx_data);
        errors++;
        rif.rx_ready = 1'b1;
        @(negedge clk);
        rif.rx_ready = 1'b0;
      end else begin
        exp = exp_q.pop_front();
        if (rif.rx_data !== exp) begin
          $display("FAIL drain_data got %h want %h", rif.rx_data, exp);
          errors++;
        end
        rif.rx_ready = 1'b1;
        @(negedge clk);
        rif.rx_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rif.rx_valid, rif.rx_data, frame_err, overrun, busy} !== '0) begin
      $display("FAIL reset_outputs got v=%b d=%h fe=%b ov=%b bz=%b want 0",
               rif.rx_valid, rif.rx_data, frame_err, overrun, busy);
      errors++;
    end
  endtask

  task automatic test_single();
    exp_q.push_back(8'h41);
    send(8'h41, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (rif.rx_valid !== 1'b1) begin
      $display("FAIL single_valid got %b want 1", rif.rx_valid);
      errors++;
    end
    checks++;
    if (frame_err !== 1'b0) begin
      $display("FAIL single_ferr got %b want 0", frame_err);
      errors++;
    end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL single_busy got %b want 0", busy);
      errors++;
    end
    drain(1);
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); din = 1'b0; end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      din = 1'b1;
      if (busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      $display("FAIL glitch_seen got %b want 1", seen);
      errors++;
    end
    checks++;
    if ({busy, rif.rx_valid} !== 2'b00) begin
      $display("FAIL glitch_idle got bz=%b v=%b want 0 0", busy, rif.rx_valid);
      errors++;
    end
  endtask

  task automatic test_frame_err();
    send(8'h55, 1'b0, -1);
    repeat (20) @(negedge clk);
    checks++;
    if (frame_err !== 1'b1) begin
      $display("FAIL ferr_set got %b want 1", frame_err);
      errors++;
    end
    checks++;
    if (rif.rx_valid !== 1'b0) begin
      $display("FAIL ferr_empty got %b want 0", rif.rx_valid);
      errors++;
    end
    exp_q.push_back(8'h33);
    send(8'h33, 1'b1, -1);
    drain(1);
  endtask

  task automatic test_pop_full();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      send(8'(8'h10 + i), 1'b1, -1);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(8'h15);
    send(8'h15, 1'b1, 10);
    checks++;
    if (overrun !== 1'b0) begin
      $display("FAIL popfull_overrun got %b want 0", overrun);
      errors++;
    end
    drain(4);
    @(negedge clk);
    checks++;
    if (rif.rx_valid !== 1'b0) begin
      $display("FAIL popfull_empty got %b want 0", rif.rx_valid);
      errors++;
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send(8'(i), 1'b1, -1);
    end
    checks++;
    if (overrun !== 1'b1) begin
      $display("FAIL overrun_set got %b want 1", overrun);
      errors++;
    end
    drain(4);
    @(negedge clk);
    checks++;
    if (rif.rx_valid !== 1'b0) begin
      $display("FAIL overrun_empty got %b want 0", rif.rx_valid);
      errors++;
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] b;
    b = 8'h7E;
    send(8'h5A, 1'b1, -1);
    for (int i = 0; i < DIV; i++) begin @(negedge clk); din = 1'b0; end
    for (int i = 0; i < 3 * DIV + DIV / 2; i++) begin
      @(negedge clk);
      din = b[i / DIV];
    end
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL midrst_busy got %b want 1", busy);
      errors++;
    end
    @(negedge clk);
    rst = 1'b1;
    din = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    checks++;
    if ({rif.rx_valid, rif.rx_data, frame_err, overrun, busy} !== '0) begin
      $display("FAIL midrst_outputs got v=%b d=%h fe=%b ov=%b bz=%b want 0",
               rif.rx_valid, rif.rx_data, frame_err, overrun, busy);
      errors++;
    end
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1, -1);
    drain(1);
    checks++;
    if (frame_err !== 1'b0) begin
      $display("FAIL midrst_ferr got %b want 0", frame_err);
      errors++;
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] b;
    b = 8'h07;
    for (int i = 0; i < DIV; i++) begin @(negedge clk); din = 1'b0; end
    for (int k = 0; k < DW; k++)
      for (int i = 0; i < DIV; i++) begin @(negedge clk); din = b[k]; end
    for (int i = 0; i < DIV; i++) begin @(negedge clk); din = 1'b0; end
    for (int i = 0; i < DIV; i++) begin @(negedge clk); din = 1'b1; end
    repeat (4) @(negedge clk);
    checks++;
    if (parity_err !== 1'b1) begin
      $display("FAIL parity_set got %b want 1", parity_err);
      errors++;
    end
    checks++;
    if (rif.rx_valid !== 1'b0) begin
      $display("FAIL parity_discard got %b want 0", rif.rx_valid);
      errors++;
    end
  endtask
`endif

  initial begin
    rif.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_pop_full();
    test_overrun();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
